// File: rtl/pc16_rstack_pkg.sv
// Shared definitions for the pc16_rstack program counter.
//   WORD_W      : program counter / return address width
//   RESET_VEC   : address loaded on reset and on CLR
//   action_t    : one action per cycle, chosen by fixed strobe priority
//   select_action() : maps the five strobes onto a single action
package pc16_rstack_pkg;

  localparam int          WORD_W    = 16;
  localparam logic [15:0] RESET_VEC = 16'h0000;

  typedef enum logic [2:0] {
    ACT_HOLD = 3'd0,
    ACT_INC  = 3'd1,
    ACT_LOAD = 3'd2,
    ACT_CALL = 3'd3,
    ACT_RET  = 3'd4,
    ACT_CLR  = 3'd5
  } action_t;

  // Priority CLR > RET > CALL > LOAD > INC > hold. Lower strobes raised
  // together with a higher one are discarded entirely.
  function automatic action_t select_action(input logic clr,
                                            input logic ret,
                                            input logic call,
                                            input logic load,
                                            input logic inc);
    action_t act;
    if (clr)       act = ACT_CLR;
    else if (ret)  act = ACT_RET;
    else if (call) act = ACT_CALL;
    else if (load) act = ACT_LOAD;
    else if (inc)  act = ACT_INC;
    else           act = ACT_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/pc16_rstack_inc16.sv
// 16-bit incrementer built as a ripple chain of XOR/AND half-adders.
//   a : input word
//   y : a + 1, modulo 2^16 (0xFFFF wraps to 0x0000, carry-out dropped)
module pc16_rstack_inc16
  import pc16_rstack_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] y
);

  // carry[0] is the constant +1 injected at the LSB.
  logic [WORD_W-1:0] carry;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_ha
      assign y[gi] = a[gi] ^ carry[gi];
      // The carry out of the top bit is the wrap and is intentionally dropped.
      if (gi < WORD_W - 1) begin : g_carry
        assign carry[gi+1] = a[gi] & carry[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/pc16_rstack.sv
// 16-bit program counter with a DEPTH-entry hardware return-address stack.
//   clk   : sole clock, rising edge
//   reset : asynchronous active-high reset
//   D     : jump / call target
//   CLR   : synchronous clear of Q, stack count and ERR
//   RET   : pop return address into Q
//   CALL  : push Q+1 and jump to D
//   LOAD  : jump to D
//   INC   : Q <= Q+1
//   Q     : current program counter (registered)
//   EMPTY : stack count == 0
//   FULL  : stack count == DEPTH
//   ERR   : sticky overflow/underflow flag, cleared by reset or CLR
module pc16_rstack
  import pc16_rstack_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] D,
  input  logic              CLR,
  input  logic              RET,
  input  logic              CALL,
  input  logic              LOAD,
  input  logic              INC,
  output logic [WORD_W-1:0] Q,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ERR
);

  // SP counts 0..DEPTH inclusive, so it needs one more code than an index.
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] q_reg, q_next;
  logic [SP_W-1:0]   sp_reg, sp_next;
  logic              err_reg, err_next;
  logic              push_en;

  logic [WORD_W-1:0] stack_mem [DEPTH];

  logic [WORD_W-1:0] q_inc;
  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              empty_w;
  logic              full_w;
  action_t           action;

  // Single incrementer shared by the INC path and the CALL return address.
  pc16_rstack_inc16 u_inc (
    .a (q_reg),
    .y (q_inc)
  );

  assign empty_w  = (sp_reg == '0);
  assign full_w   = (sp_reg == SP_W'(DEPTH));
  assign sp_dec   = sp_reg - SP_W'(1);
  // Truncation is safe: a push only happens with SP < DEPTH and a pop
  // only with SP > 0, so both indices are always inside the array.
  assign push_idx = sp_reg[IDX_W-1:0];
  assign pop_idx  = sp_dec[IDX_W-1:0];

  assign action = select_action(CLR, RET, CALL, LOAD, INC);

  always_comb begin
    q_next   = q_reg;
    sp_next  = sp_reg;
    err_next = err_reg;
    push_en  = 1'b0;
    case (action)
      ACT_CLR: begin
        q_next   = RESET_VEC;
        sp_next  = '0;
        err_next = 1'b0;
      end
      ACT_RET: begin
        if (!empty_w) begin
          q_next  = stack_mem[pop_idx];
          sp_next = sp_dec;
        end else begin
          err_next = 1'b1;
        end
      end
      ACT_CALL: begin
        // On overflow the jump is suppressed as well as the push.
        if (!full_w) begin
          push_en = 1'b1;
          q_next  = D;
          sp_next = sp_reg + SP_W'(1);
        end else begin
          err_next = 1'b1;
        end
      end
      ACT_LOAD: q_next = D;
      ACT_INC:  q_next = q_inc;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg   <= RESET_VEC;
      sp_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      sp_reg  <= sp_next;
      err_reg <= err_next;
    end
  end

  // Stack contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= q_inc;
    end
  end

  assign Q     = q_reg;
  assign EMPTY = empty_w;
  assign FULL  = full_w;
  assign ERR   = err_reg;

endmodule
